fft_stage_r2: RTL and testbench

Generic pipelined radix-2 DIT stage for the 8-point FFT datapath. It replaces the fixed per-stage wrappers with one block.
- Stage index chosen by parameter.
- Twiddles generated internally in forward or inverse mode.
- Valid pipelining, output saturation and a sticky overflow flag.
- Three instances chained S=0,1,2 form the full transform.

---
 rtl/fft_stage_r2.sv | 200 ++++++++++++++++++++
 tb/tb_fft_stage_r2.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_r2.sv
// One pipelined radix-2 DIT stage of the 8-point FFT (stage index S, latency 2).
// Build macro FFT_STAGE_SCALE_EN halves every output; ovf is then held 0.
module fft_stage_r2 #(
    parameter int unsigned N = 3,
    parameter int unsigned S = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [8*(2**N)-1:0] in_r,
    input  logic [8*(2**N)-1:0] in_i,
    input  logic                in_valid,
    input  logic                inverse,
    input  logic                clr_ovf,
    output logic [8*(2**N)-1:0] out_r,
    output logic [8*(2**N)-1:0] out_i,
    output logic                out_valid,
    output logic                ovf
);
    localparam int unsigned W = 2 ** N;
    localparam int unsigned H = 2 ** S;
    localparam int unsigned KSTEP = 4 / H;
    // C = round(sqrt(1/2) * 2^(W-1)) in integer arithmetic (46341 / 2^16 ~ sqrt(1/2))
    localparam longint CVAL = (longint'(46341) * (longint'(1) << (W - 1)) + 32768) >>> 16;
    localparam logic signed [2*W+1:0] CW  = (2*W+2)'(CVAL);
    localparam logic signed [2*W+1:0] RND = (2*W+2)'(longint'(1) << (W - 2));
    localparam logic signed [W+1:0] MAXV = (W+2)'((1 << (W - 1)) - 1);
    localparam logic signed [W+1:0] MINV = (W+2)'(-(1 << (W - 1)));

    function automatic int unsigned lo_idx(input int unsigned p);
        return ((p >> S) << (S + 1)) | (p & (H - 1));
    endfunction

    function automatic int unsigned hi_idx(input int unsigned p);
        return lo_idx(p) + H;
    endfunction

    function automatic int unsigned k_of(input int unsigned p);
        return (p & (H - 1)) * KSTEP;
    endfunction

    function automatic logic signed [W:0] cmul(input logic signed [W:0] s);
        logic signed [2*W+1:0] p;
        p = (2*W+2)'(s);
        p = p * CW + RND;
        p = p >>> (W - 1);
        return p[W:0];
    endfunction

    // Returns {re, im} of b * W8^k, conjugated twiddle when inv is set.
    function automatic logic [2*W+1:0] twiddle(input logic signed [W:0] br,
                                               input logic signed [W:0] bi,
                                               input int unsigned     k,
                                               input logic            inv);
        logic signed [W:0] tr;
        logic signed [W:0] ti;
        tr = br;
        ti = bi;
        case (k)
            1: begin
                if (inv) begin
                    tr = cmul(br - bi);
                    ti = cmul(br + bi);
                end else begin
                    tr = cmul(br + bi);
                    ti = cmul(bi - br);
                end
            end
            2: begin
                if (inv) begin
                    tr = -bi;
                    ti = br;
                end else begin
                    tr = bi;
                    ti = -br;
                end
            end
            3: begin
                if (inv) begin
                    tr = cmul(-br - bi);
                    ti = cmul(br - bi);
                end else begin
                    tr = cmul(bi - br);
                    ti = cmul(-br - bi);
                end
            end
            default: ;
        endcase
        return {tr, ti};
    endfunction

    // Returns {saturated, result[W-1:0]}.
    function automatic logic [W:0] bfly(input logic signed [W:0] a,
                                        input logic signed [W:0] b,
                                        input logic            sub);
        logic signed [W+1:0] s;
        s = sub ? ((W+2)'(a) - (W+2)'(b)) : ((W+2)'(a) + (W+2)'(b));
`ifdef FFT_STAGE_SCALE_EN
        s = (s + (W+2)'(1)) >>> 1;
`endif
        if (s > MAXV) return {1'b1, MAXV[W-1:0]};
        if (s < MINV) return {1'b1, MINV[W-1:0]};
        return {1'b0, s[W-1:0]};
    endfunction

    logic signed [W:0] x_r [8];
    logic signed [W:0] x_i [8];
    logic signed [W:0] t_r_d [8];
    logic signed [W:0] t_i_d [8];
    logic signed [W:0] t_r_q [8];
    logic signed [W:0] t_i_q [8];
    logic [2*W+1:0]    tw;
    logic              v1_q;

    logic [8*W-1:0] out_r_d, out_i_d, out_r_q, out_i_q;
    logic [W:0]     res;
    logic           sat_any;
    logic           out_valid_q;
    logic           ovf_d, ovf_q;

    always_comb begin
        tw = '0;
        for (int k = 0; k < 8; k++) begin
            x_r[k] = (W+1)'($signed(in_r[k*W +: W]));
            x_i[k] = (W+1)'($signed(in_i[k*W +: W]));
        end
        t_r_d = x_r;
        t_i_d = x_i;
        for (int p = 0; p < 4; p++) begin
            tw = twiddle(x_r[hi_idx(p)], x_i[hi_idx(p)], k_of(p), inverse);
            t_r_d[hi_idx(p)] = tw[2*W+1:W+1];
            t_i_d[hi_idx(p)] = tw[W:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_r_q <= '{default: '0};
            t_i_q <= '{default: '0};
            v1_q  <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                t_r_q <= t_r_d;
                t_i_q <= t_i_d;
            end
        end
    end

    always_comb begin
        out_r_d = '0;
        out_i_d = '0;
        res     = '0;
        sat_any = 1'b0;
        for (int p = 0; p < 4; p++) begin
            res = bfly(t_r_q[lo_idx(p)], t_r_q[hi_idx(p)], 1'b0);
            out_r_d[lo_idx(p)*W +: W] = res[W-1:0];
            sat_any = sat_any | res[W];
            res = bfly(t_i_q[lo_idx(p)], t_i_q[hi_idx(p)], 1'b0);
            out_i_d[lo_idx(p)*W +: W] = res[W-1:0];
            sat_any = sat_any | res[W];
            res = bfly(t_r_q[lo_idx(p)], t_r_q[hi_idx(p)], 1'b1);
            out_r_d[hi_idx(p)*W +: W] = res[W-1:0];
            sat_any = sat_any | res[W];
            res = bfly(t_i_q[lo_idx(p)], t_i_q[hi_idx(p)], 1'b1);
            out_i_d[hi_idx(p)*W +: W] = res[W-1:0];
            sat_any = sat_any | res[W];
        end
    end

    // A saturation on a valid output overrides a simultaneous clear.
    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf) ovf_d = 1'b0;
`ifndef FFT_STAGE_SCALE_EN
        if (v1_q && sat_any) ovf_d = 1'b1;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_r_q     <= '0;
            out_i_q     <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            ovf_q       <= ovf_d;
            if (v1_q) begin
                out_r_q <= out_r_d;
                out_i_q <= out_i_d;
            end
        end
    end

    assign out_r     = out_r_q;
    assign out_i     = out_i_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fft_stage_r2.sv
// Directed bench for fft_stage_r2: three instances (S=0,1,2) on shared inputs.
module tb_fft_stage_r2;
    localparam int W = 8;
`ifdef FFT_STAGE_SCALE_EN
    localparam int OVF_EXP = 0;
`else
    localparam int OVF_EXP = 1;
`endif

    logic           clk = 1'b0;
    logic           rst, in_valid, inverse, clr_ovf;
    logic [8*W-1:0] in_r, in_i;
    logic [8*W-1:0] o_r [3];
    logic [8*W-1:0] o_i [3];
    logic           ov [3];
    logic           of [3];
    logic signed [W-1:0] xr [8];
    logic signed [W-1:0] xi [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_stage_r2 #(.N(3), .S(0)) u0 (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
        .inverse(inverse), .clr_ovf(clr_ovf), .out_r(o_r[0]), .out_i(o_i[0]),
        .out_valid(ov[0]), .ovf(of[0])
    );
    fft_stage_r2 #(.N(3), .S(1)) u1 (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
        .inverse(inverse), .clr_ovf(clr_ovf), .out_r(o_r[1]), .out_i(o_i[1]),
        .out_valid(ov[1]), .ovf(of[1])
    );
    fft_stage_r2 #(.N(3), .S(2)) u2 (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
        .inverse(inverse), .clr_ovf(clr_ovf), .out_r(o_r[2]), .out_i(o_i[2]),
        .out_valid(ov[2]), .ovf(of[2])
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int comp(input logic [8*W-1:0] v, input int k);
        return int'($signed(v[k*W +: W]));
    endfunction

    // Expected stage output for an unsaturated unscaled value.
    function automatic int sc(input int v);
`ifdef FFT_STAGE_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    task automatic clear_x;
        for (int k = 0; k < 8; k++) begin
            xr[k] = '0;
            xi[k] = '0;
        end
    endtask

    task automatic apply(input logic v, input logic inv);
        for (int k = 0; k < 8; k++) begin
            in_r[k*W +: W] = xr[k];
            in_i[k*W +: W] = xi[k];
        end
        in_valid = v;
        inverse  = inv;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        clr_ovf = 1'b0;
        clear_x();
        apply(1'b0, 1'b0);
        #1;
        check("rst valid u0", int'(ov[0]), 0);
        check("rst ovf u0", int'(of[0]), 0);
        check("rst out_r u2", comp(o_r[2], 1), 0);
        tick();
        rst = 1'b0;
        tick();

        // S=1: x1=5, x3=j20
        clear_x();
        xr[1] = 8'sd5;
        xi[3] = 8'sd20;
        apply(1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0);
        check("s1 latency", int'(ov[1]), 0);
        tick();
        check("s1 valid", int'(ov[1]), 1);
        check("s1 out1 re", comp(o_r[1], 1), sc(25));
        check("s1 out1 im", comp(o_i[1], 1), sc(0));
        check("s1 out3 re", comp(o_r[1], 3), sc(-15));
        check("s1 out3 im", comp(o_i[1], 3), sc(0));

        // S=2: x5=100, forward then inverse
        clear_x();
        xr[5] = 8'sd100;
        apply(1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0);
        tick();
        check("s2 fwd out1 re", comp(o_r[2], 1), sc(71));
        check("s2 fwd out1 im", comp(o_i[2], 1), sc(-71));
        check("s2 fwd out5 re", comp(o_r[2], 5), sc(-71));
        check("s2 fwd out5 im", comp(o_i[2], 5), sc(71));
        apply(1'b1, 1'b1);
        tick();
        apply(1'b0, 1'b0);
        tick();
        check("s2 inv out1 re", comp(o_r[2], 1), sc(71));
        check("s2 inv out1 im", comp(o_i[2], 1), sc(71));
        check("s2 inv out5 re", comp(o_r[2], 5), sc(-71));
        check("s2 inv out5 im", comp(o_i[2], 5), sc(-71));
        check("s0 ovf clean", int'(of[0]), 0);

        // S=0 saturation: x0=x1=127
        clear_x();
        xr[0] = 8'sd127;
        xr[1] = 8'sd127;
        apply(1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0);
        tick();
        check("sat out0 re", comp(o_r[0], 0), 127);
        check("sat out1 re", comp(o_r[0], 1), 0);
        check("sat ovf", int'(of[0]), OVF_EXP);
        clear_x();
        xr[0] = 8'sd1;
        apply(1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0);
        tick();
        check("clean out0 re", comp(o_r[0], 0), sc(1));
        check("ovf sticky", int'(of[0]), OVF_EXP);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("ovf cleared", int'(of[0]), 0);

        // Saturation coinciding with clr_ovf: set wins
        clear_x();
        xr[0] = 8'sd127;
        xr[1] = 8'sd127;
        apply(1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("set beats clr", int'(of[0]), OVF_EXP);
        check("pre-rst valid", int'(ov[0]), 1);

        // Asynchronous reset while out_valid is high
        #1;
        rst = 1'b1;
        #1;
        check("rst mid valid", int'(ov[0]), 0);
        check("rst mid out_r", comp(o_r[0], 0), 0);
        check("rst mid out_i", comp(o_i[0], 0), 0);
        check("rst mid ovf", int'(of[0]), 0);
        #1;
        rst = 1'b0;
        tick();
        check("post-rst idle", int'(ov[1]), 0);
        clear_x();
        xr[1] = 8'sd5;
        xi[3] = 8'sd20;
        apply(1'b1, 1'b0);
        tick();
        apply(1'b0, 1'b0);
        check("post-rst latency", int'(ov[1]), 0);
        tick();
        check("post-rst valid", int'(ov[1]), 1);
        check("post-rst out1 re", comp(o_r[1], 1), sc(25));

        // S=2 valid pattern 1,1,0,1 with per-vector inverse
        clear_x();
        xr[5] = 8'sd100;
        apply(1'b1, 1'b0);
        tick();
        check("pat e1 valid", int'(ov[2]), 0);
        xr[1] = 8'sd1;
        apply(1'b1, 1'b1);
        tick();
        check("pat A valid", int'(ov[2]), 1);
        check("pat A out1 re", comp(o_r[2], 1), sc(71));
        check("pat A out1 im", comp(o_i[2], 1), sc(-71));
        check("pat A out5 re", comp(o_r[2], 5), sc(-71));
        apply(1'b0, 1'b0);
        tick();
        check("pat B valid", int'(ov[2]), 1);
        check("pat B out1 re", comp(o_r[2], 1), sc(72));
        check("pat B out1 im", comp(o_i[2], 1), sc(71));
        check("pat B out5 re", comp(o_r[2], 5), sc(-70));
        check("pat B out5 im", comp(o_i[2], 5), sc(-71));
        clear_x();
        xr[0] = 8'sd10;
        xr[4] = 8'sd20;
        apply(1'b1, 1'b1);
        tick();
        check("pat gap valid", int'(ov[2]), 0);
        check("pat gap hold", comp(o_r[2], 1), sc(72));
        apply(1'b0, 1'b0);
        tick();
        check("pat C valid", int'(ov[2]), 1);
        check("pat C out0 re", comp(o_r[2], 0), sc(30));
        check("pat C out4 re", comp(o_r[2], 4), sc(-10));
        check("pat C out1 re", comp(o_r[2], 1), sc(0));
        tick();
        check("pat end valid", int'(ov[2]), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
